instr_fetch_queue: RTL and testbench

//  Instruction fetch queue between the cache controller and dual-issue decode.
//  - Accepts one 128-bit fetch packet per cycle: two instructions and their PCs.
//  - Buffers packets in order and presents the head packet to decode as two slots.
//  - Back-pressures fetch through stop_fetch.
//  - Empties completely on a pipeline flush (taken jump).

---
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: buffers 128-bit fetch packets for dual-issue decode with show-ahead head.
// Optional full-cycle performance counter enabled by defining IFQ_PERF_EN.
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_fifo,
  input  logic [127:0]             fetch_instr_pc,
  input  logic                     flush,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [31:0]              dec_instr0,
  output logic [31:0]              dec_pc0,
  output logic [31:0]              dec_instr1,
  output logic [31:0]              dec_pc1,
  output logic                     stop_fetch,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]              perf_full_cycles
`endif
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic [127:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_next;
  logic [127:0]     head;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full      = (count == CNT_W'(DEPTH));
  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready & ~flush;
  assign push      = write_fifo & ~flush & (~full | pop);
  assign drop      = write_fifo & ~flush & full & ~pop;

  // Show-ahead head, zeroed while empty so stale storage never leaks out.
  assign head       = mem[rd_ptr];
  assign dec_instr0 = dec_valid ? head[63:32]  : '0;
  assign dec_pc0    = dec_valid ? head[31:0]   : '0;
  assign dec_instr1 = dec_valid ? head[127:96] : '0;
  assign dec_pc1    = dec_valid ? head[95:64]  : '0;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fetch_instr_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      stop_fetch   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      count      <= count_next;
      stop_fetch <= ~flush & (count_next >= CNT_W'(AF_LEVEL));
      if (flush) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        overflow_err <= 1'b0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (drop) begin
          overflow_err <= 1'b1;
        end
      end
    end
  end

`ifdef IFQ_PERF_EN
  // Saturating count of cycles spent full; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_cycles <= '0;
    end else if (full && (perf_full_cycles != 32'hFFFF_FFFF)) begin
      perf_full_cycles <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed table-driven bench for instr_fetch_queue (DEPTH=8, AF_MARGIN=2) plus random in-order stream.
module tb_instr_fetch_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_fifo;
  logic [127:0] fetch_instr_pc;
  logic         flush;
  logic         dec_ready;
  logic         dec_valid;
  logic [31:0]  dec_instr0;
  logic [31:0]  dec_pc0;
  logic [31:0]  dec_instr1;
  logic [31:0]  dec_pc1;
  logic         stop_fetch;
  logic [3:0]   count;
  logic         overflow_err;
`ifdef IFQ_PERF_EN
  logic [31:0]  perf_full_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int perf_exp = 0;

  instr_fetch_queue #(.DEPTH(8), .AF_MARGIN(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .write_fifo(write_fifo),
    .fetch_instr_pc(fetch_instr_pc),
    .flush(flush),
    .dec_ready(dec_ready),
    .dec_valid(dec_valid),
    .dec_instr0(dec_instr0),
    .dec_pc0(dec_pc0),
    .dec_instr1(dec_instr1),
    .dec_pc1(dec_pc1),
    .stop_fetch(stop_fetch),
    .count(count),
    .overflow_err(overflow_err)
`ifdef IFQ_PERF_EN
    ,
    .perf_full_cycles(perf_full_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit wf;
    int pkt;   // packet index driven, -1 drives zero
    bit fl;
    bit rdy;
    int head;  // expected head packet index, -1 when empty
    bit stop;
    int cnt;
    bit ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] mk(input int k);
    logic [31:0] pc0;
    pc0 = 32'h0000_1000 + 32'(k) * 32'd8;
    return {32'hB000_0000 + 32'(k), pc0 + 32'd4, 32'hA000_0000 + 32'(k), pc0};
  endfunction

  function automatic vec_t mkv(input bit wf, input int pkt, input bit fl, input bit rdy,
                               input int head, input bit stop, input int cnt, input bit ovf);
    vec_t v;
    v.wf = wf; v.pkt = pkt; v.fl = fl; v.rdy = rdy;
    v.head = head; v.stop = stop; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string tag, input int head);
    logic [127:0] p;
    p = (head < 0) ? 128'd0 : mk(head);
    chk({tag, " dec_valid"}, 32'(dec_valid), (head < 0) ? 32'd0 : 32'd1);
    chk({tag, " dec_pc0"}, dec_pc0, p[31:0]);
    chk({tag, " dec_instr0"}, dec_instr0, p[63:32]);
    chk({tag, " dec_instr1"}, dec_instr1, p[127:96]);
  endtask

  initial begin
    int prev_cnt;
    int mcnt;
    int sent;
    int recv;
    int cyc;
    bit rdy;
    bit pop_m;
    bit wf_m;

    rst_n = 1'b0; write_fifo = 1'b0; fetch_instr_pc = '0; flush = 1'b0; dec_ready = 1'b0;
    #23;
    chk("reset count", 32'(count), 32'd0);
    chk("reset stop_fetch", 32'(stop_fetch), 32'd0);
    chk("reset overflow_err", 32'(overflow_err), 32'd0);
    chk_head("reset", -1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //               wf pkt fl rdy head stop cnt ovf
    vecs.push_back(mkv(1,  0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mkv(1,  1, 0, 0,  0, 0, 2, 0));
    vecs.push_back(mkv(1,  2, 0, 0,  0, 0, 3, 0));
    vecs.push_back(mkv(1,  3, 0, 0,  0, 0, 4, 0));
    vecs.push_back(mkv(1,  4, 0, 0,  0, 0, 5, 0));
    vecs.push_back(mkv(1,  5, 0, 0,  0, 1, 6, 0));
    vecs.push_back(mkv(1,  6, 0, 0,  0, 1, 7, 0));
    vecs.push_back(mkv(1,  7, 0, 0,  0, 1, 8, 0));
    vecs.push_back(mkv(1,  8, 0, 1,  1, 1, 8, 0));
    vecs.push_back(mkv(1,  9, 0, 1,  2, 1, 8, 0));
    vecs.push_back(mkv(1, 10, 0, 1,  3, 1, 8, 0));
    vecs.push_back(mkv(1, 11, 0, 1,  4, 1, 8, 0));
    vecs.push_back(mkv(1, 12, 0, 0,  4, 1, 8, 1));
    vecs.push_back(mkv(0, -1, 0, 0,  4, 1, 8, 1));
    vecs.push_back(mkv(0, -1, 0, 1,  5, 1, 7, 1));
    vecs.push_back(mkv(0, -1, 0, 1,  6, 1, 6, 1));
    vecs.push_back(mkv(0, -1, 0, 1,  7, 0, 5, 1));
    vecs.push_back(mkv(1, 13, 1, 1, -1, 0, 0, 0));
    vecs.push_back(mkv(1, 14, 0, 0, 14, 0, 1, 0));
    vecs.push_back(mkv(0, -1, 0, 1, -1, 0, 0, 0));
    vecs.push_back(mkv(0, -1, 0, 1, -1, 0, 0, 0));
    vecs.push_back(mkv(1, 15, 0, 1, 15, 0, 1, 0));
    vecs.push_back(mkv(0, -1, 0, 1, -1, 0, 0, 0));

    prev_cnt = 0;
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      write_fifo     = vecs[i].wf;
      fetch_instr_pc = (vecs[i].pkt < 0) ? 128'd0 : mk(vecs[i].pkt);
      flush          = vecs[i].fl;
      dec_ready      = vecs[i].rdy;
      if (prev_cnt == 8) perf_exp++;
      @(posedge clk); #1;
      chk({tag, " count"}, 32'(count), 32'(vecs[i].cnt));
      chk({tag, " stop_fetch"}, 32'(stop_fetch), 32'(vecs[i].stop));
      chk({tag, " overflow_err"}, 32'(overflow_err), 32'(vecs[i].ovf));
      chk_head(tag, vecs[i].head);
      prev_cnt = vecs[i].cnt;
    end

    // Random-readiness stream of 24 packets through the wrapping pointers.
    mcnt = 0; sent = 0; recv = 0; cyc = 0;
    flush = 1'b0;
    while (recv < 24 && cyc < 1000) begin
      rdy   = ($urandom_range(0, 2) == 0);
      pop_m = (mcnt != 0) && rdy;
      wf_m  = (sent < 24) && ((mcnt < 8) || pop_m);
      dec_ready      = rdy;
      write_fifo     = wf_m;
      fetch_instr_pc = wf_m ? mk(100 + sent) : 128'd0;
      if (mcnt == 8) perf_exp++;
      if (pop_m) begin
        chk("stream dec_pc0", dec_pc0, mk(100 + recv) >> 0);
        chk("stream dec_instr1", dec_instr1, 32'hB000_0000 + 32'(100 + recv));
        recv++;
      end
      if (wf_m) sent++;
      @(posedge clk); #1;
      mcnt = mcnt + (wf_m ? 1 : 0) - (pop_m ? 1 : 0);
      chk("stream count", 32'(count), 32'(mcnt));
      chk("stream stop_fetch", 32'(stop_fetch), (mcnt >= 6) ? 32'd1 : 32'd0);
      cyc++;
    end
    chk("stream packets drained", 32'(recv), 32'd24);
    chk("stream overflow_err", 32'(overflow_err), 32'd0);
    write_fifo = 1'b0; dec_ready = 1'b0;
`ifdef IFQ_PERF_EN
    chk("perf_full_cycles", perf_full_cycles, 32'(perf_exp));
`endif

    // Asynchronous reset in the middle of a cycle with data queued.
    for (int k = 0; k < 3; k++) begin
      write_fifo = 1'b1; fetch_instr_pc = mk(200 + k);
      @(posedge clk); #1;
    end
    write_fifo = 1'b0;
    chk("pre-reset count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count", 32'(count), 32'd0);
    chk("async reset stop_fetch", 32'(stop_fetch), 32'd0);
    chk_head("async reset", -1);
`ifdef IFQ_PERF_EN
    chk("async reset perf", perf_full_cycles, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    write_fifo = 1'b1; fetch_instr_pc = mk(300);
    @(posedge clk); #1;
    write_fifo = 1'b0;
    chk("post-reset count", 32'(count), 32'd1);
    chk_head("post-reset", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
